// File: rtl/prco_uart_rx_if.sv
// Handshake and line bundle between the UART receiver and its consumer.
// The receiver uses the slave view; whoever drives the line and consumes bytes uses the master view.
interface prco_uart_rx_if;
    logic       i_en;
    logic       i_rx;
    logic       i_ack;
    logic       i_clr_err;
    logic [7:0] q_byte;
    logic       q_valid;
    logic       q_frame_err;
    logic       q_overrun;
    logic       q_busy;

    modport slave (
        input  i_en, i_rx, i_ack, i_clr_err,
        output q_byte, q_valid, q_frame_err, q_overrun, q_busy
    );

    modport master (
        output i_en, i_rx, i_ack, i_clr_err,
        input  q_byte, q_valid, q_frame_err, q_overrun, q_busy
    );
endinterface

// File: rtl/prco_uart_rx.sv
// UART 8N1 receiver: centre-sampled bits, one-entry holding register with valid/ack,
// sticky framing-error and overrun flags.
module prco_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    prco_uart_rx_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    // The start interval is H cycles so that every later sample lands mid-bit.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic [7:0]       data_r;
    logic             valid_r;
    logic             frame_err_r;
    logic             overrun_r;
    logic             busy_r;

    // Synchroniser, receive FSM, holding register and sticky flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_r   <= 1'b1;
            rx_sync_r   <= 1'b1;
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_meta_r <= bus.i_rx;
            rx_sync_r <= rx_meta_r;

            if (bus.i_ack && valid_r) begin
                valid_r <= 1'b0;
            end
            if (bus.i_clr_err) begin
                frame_err_r <= 1'b0;
                overrun_r   <= 1'b0;
            end

            // Flag-setting and delivery below are written later so they win over clear/ack.
            if (!bus.i_en) begin
                state_r   <= IDLE;
                busy_r    <= 1'b0;
                cnt_r     <= {CNT_W{1'b0}};
                bit_idx_r <= 3'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (!rx_sync_r) begin
                            state_r <= START;
                            busy_r  <= 1'b1;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                    START: begin
                        if (cnt_r == HALF_LAST) begin
                            cnt_r <= {CNT_W{1'b0}};
                            if (!rx_sync_r) begin
                                state_r   <= DATA;
                                bit_idx_r <= 3'd0;
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_r == BIT_LAST) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            shift_r <= {rx_sync_r, shift_r[7:1]};
                            if (bit_idx_r == 3'd7) begin
                                state_r <= STOP;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt_r == BIT_LAST) begin
                            cnt_r <= {CNT_W{1'b0}};
                            if (rx_sync_r) begin
                                data_r  <= shift_r;
                                valid_r <= 1'b1;
                                if (valid_r && !bus.i_ack) begin
                                    overrun_r <= 1'b1;
                                end
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                frame_err_r <= 1'b1;
                                state_r     <= WAIT_IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    WAIT_IDLE: begin
                        if (rx_sync_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign bus.q_byte      = data_r;
    assign bus.q_valid     = valid_r;
    assign bus.q_frame_err = frame_err_r;
    assign bus.q_overrun   = overrun_r;
    assign bus.q_busy      = busy_r;

endmodule

// File: doc/prco_uart_rx.md
Name: prco_uart_rx

Overview:
- UART 8N1 receiver feeding received bytes into prco_core's serial input path; the receive-side counterpart of the core's UART transmitter.
- Oversamples the asynchronous RX line at the system clock and samples each bit at its centre.
- Presents each completed byte in a one-entry holding register with a valid/ack handshake, plus sticky framing-error and overrun flags.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200). Minimum legal value 4.
- CNT_W, 16, counter width. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  receiver enable. While low, the FSM is forced to IDLE, any frame in progress is dropped, and the holding register and flags are kept.
- i_rx  in  1  asynchronous serial input. Idle level is high.
- i_ack  in  1  consumer acknowledge for q_byte.
- i_clr_err  in  1  clears q_frame_err and q_overrun.
- q_byte  out  8  last received byte.
- q_valid  out  1  q_byte holds an unacknowledged byte.
- q_frame_err  out  1  sticky: a stop bit was sampled low.
- q_overrun  out  1  sticky: a byte was delivered while q_valid=1 and no ack arrived in that cycle.
- q_busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high; clock and reset fixed as i_clk / i_reset):
  - Both sync flops = 1; FSM = IDLE; counters = 0.
  - q_byte=0, q_valid=0, q_frame_err=0, q_overrun=0, q_busy=0.
  - Reset mid-frame aborts the frame; no partial byte is delivered.
- Synchroniser: i_rx passes through a 2-flop sync into rx_s. All decisions use rx_s only.
- Notation: N = CLKS_PER_BIT, H = N/2 (integer division). t0 = first cycle in IDLE with rx_s=0 and i_en=1.
- FSM states and transitions:
  - IDLE: at t0, go to START and clear the counter.
  - START: at t0+H, sample rx_s. If 0, go to DATA with bit index 0. If 1 (glitch), return to IDLE with no flags raised.
  - DATA: data bit k (k=0..7, LSB first) is sampled at t0+H+(k+1)·N and shifted into the shift register. After bit 7, go to STOP.
  - STOP: sample at t0+H+9N.
    - If rx_s=1: deliver the byte and return to IDLE.
    - If rx_s=0: set q_frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay here until rx_s=1 (break or line held low), then return to IDLE. A new start cannot be detected until the line has been seen high.
- Delivery: q_byte and q_valid=1 are registered in the cycle after the stop sample, i.e. q_valid first reads high at t0+H+9N+1.
- Handshake:
  - i_ack=1 while q_valid=1 clears q_valid in the next cycle. q_byte is held.
  - i_ack while q_valid=0 is ignored.
  - Delivery with q_valid=1 and no ack in that cycle: q_byte is overwritten with the new byte, q_valid stays 1, q_overrun is set.
  - Delivery in the same cycle as ack: new byte loaded, q_valid stays 1, no overrun.
- i_clr_err clears both sticky flags next cycle. If a flag-setting event occurs in the same cycle, the set wins.
- q_busy = 1 in START, DATA, STOP and WAIT_IDLE.
- Counter behaviour:
  - Counts 0..N-1 and wraps to 0 at each sample point.
  - The first interval after t0 is H cycles; all later intervals are N cycles.
  - No cumulative drift: every sample is at exactly the cycle given above.
- Back-to-back frames: a start bit immediately after a good stop (stop sample at t0+H+9N) is detected as soon as rx_s=0 in IDLE.

Test Plan (CLKS_PER_BIT=16, so H=8):
- Send 0xA5 8N1, idle otherwise -> q_valid rises at exactly t0+153, q_byte=0xA5, flags 0. Then pulse i_ack -> q_valid=0 next cycle.
- Drive i_rx low for 3 cycles, then high -> FSM returns to IDLE at t0+8, q_valid stays 0, q_frame_err=0, q_busy back to 0.
- Send 0x5A with stop bit low, hold the line low 40 more cycles, then send 0x3C correctly -> q_frame_err=1, no delivery of 0x5A, then q_byte=0x3C with q_valid=1. i_clr_err -> q_frame_err=0.
- Send 0x11 then 0x22 back-to-back with no ack -> q_byte=0x22, q_valid=1, q_overrun=1. Repeat with i_ack asserted in the 0x22 delivery cycle -> q_overrun stays 0.
- Pulse i_reset during data bit 4 of 0xFF, then send 0x81 -> no byte from the aborted frame, all outputs 0 after reset, then q_byte=0x81.
- Deassert i_en during data bit 2, reassert, send 0x7E -> aborted frame produces nothing; 0x7E received correctly.
